// File: rtl/packer_if.sv
// Symbol-in / word-out handshake bundle for the packer.
// The slave modport is the packer side; the master modport is the driver/sink side.
interface packer_if #(
  parameter int unsigned unpacked_p   = 2,
  parameter int unsigned num_packed_p = 4
);
  localparam int unsigned W  = unpacked_p * num_packed_p;
  localparam int unsigned CW = $clog2(num_packed_p) + 1;

  logic [unpacked_p-1:0] unpacked_i;
  logic                  valid_i;
  logic                  flush_i;
  logic                  ready_o;
  logic [W-1:0]          packed_o;
  logic [CW-1:0]         count_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  unpacked_i, valid_i, flush_i, ready_i,
    output ready_o, packed_o, count_o, valid_o
  );

  modport master (
    output unpacked_i, valid_i, flush_i, ready_i,
    input  ready_o, packed_o, count_o, valid_o
  );
endinterface

// File: rtl/packer.sv
// Packs num_packed_p symbols of unpacked_p bits into one word, slot 0 in the LSBs.
// Define PACKER_FLUSH_EN to let flush_i close a partial word early.
module packer #(
  parameter int unsigned unpacked_p   = 2,
  parameter int unsigned num_packed_p = 4
) (
  input logic    clk_i,
  input logic    reset_ni,
  packer_if.slave bus
);
  localparam int unsigned W  = unpacked_p * num_packed_p;
  localparam int unsigned SW = $clog2(num_packed_p);
  localparam int unsigned CW = SW + 1;
  localparam logic [SW-1:0] LAST = SW'(num_packed_p - 1);

  logic [SW-1:0] slot_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  packed_q;
  logic [W-1:0]  word_d;
  logic [CW-1:0] count_q;
  logic          valid_q;
  logic          ready;
  logic          in_fire;
  logic          out_fire;
  logic          flush_fire;
  logic          transfer;

`ifdef PACKER_FLUSH_EN
  assign flush_fire = in_fire && bus.flush_i;
  // Any input may close a word, so the only stall is a held, unaccepted output.
  assign ready      = !valid_q || bus.ready_i;
`else
  logic unused_flush;
  assign unused_flush = bus.flush_i;
  assign flush_fire   = 1'b0;
  assign ready        = (slot_q != LAST) || !valid_q || bus.ready_i;
`endif

  assign in_fire  = bus.valid_i && ready;
  assign out_fire = valid_q && bus.ready_i;
  assign transfer = in_fire && ((slot_q == LAST) || flush_fire);

  // Accumulator with the incoming symbol merged into the current slot; upper
  // slots are still zero because the accumulator clears on every transfer.
  always_comb begin
    word_d = acc_q;
    for (int k = 0; k < num_packed_p; k++) begin
      if (slot_q == SW'(k)) word_d[k*unpacked_p +: unpacked_p] = bus.unpacked_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      slot_q   <= '0;
      acc_q    <= '0;
      packed_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (transfer) begin
        packed_q <= word_d;
        count_q  <= {1'b0, slot_q} + CW'(1);
        valid_q  <= 1'b1;
        acc_q    <= '0;
        slot_q   <= '0;
      end else begin
        if (in_fire) begin
          acc_q  <= word_d;
          slot_q <= slot_q + SW'(1);
        end
        if (out_fire) valid_q <= 1'b0;
      end
    end
  end

  assign bus.ready_o  = ready;
  assign bus.packed_o = packed_q;
  assign bus.count_o  = count_q;
  assign bus.valid_o  = valid_q;
endmodule

// File: tb/tb_packer.sv
// Randomized and directed check of packer against a symbol-queue reference model.
module tb_packer;
  localparam int U = 2;
  localparam int N = 4;
  localparam int W = U * N;

  typedef struct {
    logic [W-1:0] word;
    int           cnt;
  } word_t;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;

  packer_if #(.unpacked_p(U), .num_packed_p(N)) bus ();

  packer #(.unpacked_p(U), .num_packed_p(N)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  int           pend_q[$];
  word_t        exp_q[$];
  logic [W-1:0] out_log[$];
  int           cnt_log[$];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_syms(input int syms[$]);
    logic [W-1:0] w = '0;
    for (int i = 0; i < syms.size(); i++) w = w | (W'(syms[i]) << (i * U));
    return w;
  endfunction

  // Reference model: compare, then advance on the fires seen this cycle.
  always @(negedge clk_i) begin
    if (reset_ni) begin
      bit full;
      bit exp_rdy;
      bit flush_ok;
      word_t nw;
      full = (exp_q.size() != 0);
`ifdef PACKER_FLUSH_EN
      exp_rdy  = !full || bus.ready_i;
      flush_ok = 1'b1;
`else
      exp_rdy  = (pend_q.size() != N - 1) || !full || bus.ready_i;
      flush_ok = 1'b0;
`endif
      chk(bus.ready_o == exp_rdy, "ready_o", bus.ready_o, exp_rdy);
      chk(bus.valid_o == full, "valid_o", bus.valid_o, full);
      if (full) begin
        chk(bus.packed_o == exp_q[0].word, "packed_o", bus.packed_o, exp_q[0].word);
        chk(int'(bus.count_o) == exp_q[0].cnt, "count_o", bus.count_o, exp_q[0].cnt);
      end
      if (bus.valid_o && bus.ready_i && full) begin
        out_log.push_back(exp_q[0].word);
        cnt_log.push_back(exp_q[0].cnt);
        void'(exp_q.pop_front());
      end
      if (bus.valid_i && bus.ready_o) begin
        pend_q.push_back(int'(bus.unpacked_i));
        if (pend_q.size() == N || (flush_ok && bus.flush_i)) begin
          nw.word = pack_syms(pend_q);
          nw.cnt  = pend_q.size();
          exp_q.push_back(nw);
          pend_q.delete();
        end
      end
    end
  end

  task automatic offer(input int sym, input bit fl, output int cycles);
    bit acc;
    bus.valid_i    = 1'b1;
    bus.unpacked_i = U'(sym);
    bus.flush_i    = fl;
    cycles = 0;
    do begin
      @(negedge clk_i);
      acc = bus.ready_o;
      @(posedge clk_i);
      #1;
      cycles++;
    end while (!acc && cycles < 100);
    if (!acc) chk(1'b0, "offer_timeout", cycles, 100);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int cyc;
    int total;
    int base;
    bit done;
    int syms3[4] = '{1, 2, 3, 0};
    int syms6[6] = '{3, 1, 2, 2, 2, 2};
    int fl6[6]   = '{0, 1, 0, 0, 0, 0};

    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.unpacked_i = '0;
    bus.ready_i = 1'b1;

    // Reset state
    #2;
    chk(bus.valid_o == 1'b0, "rst_valid", bus.valid_o, 0);
    chk(bus.packed_o == '0, "rst_packed", bus.packed_o, 0);
    chk(bus.count_o == '0, "rst_count", bus.count_o, 0);
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    @(negedge clk_i);
    chk(bus.ready_o == 1'b1, "ready_after_rst", bus.ready_o, 1);
    idle(1);

    // Symbols 1,2,3,0 -> 0x39
    foreach (syms3[i]) offer(syms3[i], 1'b0, cyc);
    @(negedge clk_i);
    chk(bus.valid_o == 1'b1, "w39_valid", bus.valid_o, 1);
    chk(bus.packed_o == 8'h39, "w39_packed", bus.packed_o, 8'h39);
    chk(bus.count_o == 4, "w39_count", bus.count_o, 4);
    idle(3);

    // Backpressure: 8 symbols of 3 with ready_i low
    bus.ready_i = 1'b0;
    base = out_log.size();
    done = 1'b0;
    fork
      begin
        int c;
        for (int i = 0; i < 8; i++) offer(3, 1'b0, c);
        done = 1'b1;
      end
    join_none
    repeat (12) @(negedge clk_i);
    chk(bus.ready_o == 1'b0, "bp_ready_low", bus.ready_o, 0);
    chk(bus.valid_o == 1'b1, "bp_valid_held", bus.valid_o, 1);
    chk(bus.packed_o == 8'hFF, "bp_packed_held", bus.packed_o, 8'hFF);
    @(posedge clk_i);
    #1 bus.ready_i = 1'b1;
    for (int i = 0; i < 60 && !done; i++) idle(1);
    chk(done == 1'b1, "bp_sender_done", done, 1);
    idle(4);
    chk(out_log.size() == base + 2, "bp_word_count", out_log.size() - base, 2);
    if (out_log.size() >= base + 2) begin
      chk(out_log[base] == 8'hFF, "bp_word0", out_log[base], 8'hFF);
      chk(out_log[base+1] == 8'hFF, "bp_word1", out_log[base+1], 8'hFF);
    end

    // Streaming: 16 symbols 0,1,2,3 with no stall
    base = out_log.size();
    total = 0;
    for (int i = 0; i < 16; i++) begin
      offer(i % 4, 1'b0, cyc);
      total += cyc;
    end
    idle(3);
    chk(total == 16, "stream_cycles", total, 16);
    chk(out_log.size() == base + 4, "stream_words", out_log.size() - base, 4);
    for (int i = base; i < out_log.size(); i++)
      chk(out_log[i] == 8'hE4, "stream_word", out_log[i], 8'hE4);

    // Reset mid-word discards partial symbols
    offer(1, 1'b0, cyc);
    offer(2, 1'b0, cyc);
    @(posedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    chk(bus.valid_o == 1'b0, "midrst_valid", bus.valid_o, 0);
    chk(bus.packed_o == '0, "midrst_packed", bus.packed_o, 0);
    pend_q.delete();
    exp_q.delete();
    #1 reset_ni = 1'b1;
    base = out_log.size();
    offer(0, 1'b0, cyc);
    offer(0, 1'b0, cyc);
    offer(0, 1'b0, cyc);
    offer(1, 1'b0, cyc);
    idle(3);
    chk(out_log.size() == base + 1, "midrst_words", out_log.size() - base, 1);
    if (out_log.size() > base) chk(out_log[base] == 8'h40, "midrst_word", out_log[base], 8'h40);

    // Flush stimulus: 3, 1(flush), 2,2,2,2
    base = out_log.size();
    foreach (syms6[i]) offer(syms6[i], fl6[i][0], cyc);
    idle(3);
`ifdef PACKER_FLUSH_EN
    chk(out_log.size() == base + 2, "flush_words", out_log.size() - base, 2);
    if (out_log.size() >= base + 2) begin
      chk(out_log[base] == 8'h07, "flush_word0", out_log[base], 8'h07);
      chk(cnt_log[base] == 2, "flush_cnt0", cnt_log[base], 2);
      chk(out_log[base+1] == 8'hAA, "flush_word1", out_log[base+1], 8'hAA);
      chk(cnt_log[base+1] == 4, "flush_cnt1", cnt_log[base+1], 4);
    end
`else
    chk(out_log.size() == base + 1, "noflush_words", out_log.size() - base, 1);
    if (out_log.size() > base) begin
      chk(out_log[base] == 8'hA7, "noflush_word0", out_log[base], 8'hA7);
      chk(cnt_log[base] == 4, "noflush_cnt0", cnt_log[base], 4);
    end
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(posedge clk_i);
      #1;
      bus.valid_i    = ($urandom_range(0, 3) != 0);
      bus.unpacked_i = U'($urandom);
      bus.flush_i    = ($urandom_range(0, 5) == 0);
      bus.ready_i    = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    end
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    idle(5);
    chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/packer.md
PACKER -- requirements
Module: packer

Interface
REQ-001 Parameter unpacked_p, default 2, width in bits of one input symbol.
REQ-002 Parameter num_packed_p, default 4, symbols per packed word; packed width W = unpacked_p*num_packed_p (default 8).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 unpacked_i  input  unpacked_p  input symbol.
REQ-006 valid_i  input  1  unpacked_i (and flush_i) valid.
REQ-007 flush_i  input  1  marks the accompanying symbol as last of a partial word.
REQ-008 ready_o  output  1  packer can accept a symbol this cycle.
REQ-009 packed_o  output  W  packed word.
REQ-010 count_o  output  $clog2(num_packed_p)+1  number of valid symbols in packed_o.
REQ-011 valid_o  output  1  packed_o/count_o valid.
REQ-012 ready_i  input  1  downstream accepts packed_o.

Function
REQ-013 Input fire = valid_i && ready_o; output fire = valid_o && ready_i.
REQ-014 Slot counter runs 0..num_packed_p-1, increments on each input fire, and wraps to 0 when a word is emitted.
REQ-015 Symbol accepted at slot k is placed at packed bits [k*unpacked_p +: unpacked_p]; slot 0 is the LSBs, which inverts the unpacker ordering exactly.
REQ-016 Accepting the symbol at slot num_packed_p-1 transfers the completed word to the output register; valid_o rises the following cycle; count_o = num_packed_p.
REQ-017 Accumulator and counter clear on transfer, so the next symbol may be accepted in the same cycle as the word is presented.
REQ-018 Output register holds packed_o/count_o stable while valid_o && !ready_i; valid_o clears after output fire unless a new word is transferred in the same cycle.
REQ-019 ready_o = (slot != num_packed_p-1) || !valid_o || ready_i; no combinational path from valid_i or unpacked_i to ready_o.
REQ-020 Sustained throughput is one symbol per cycle (one word per num_packed_p cycles) with ready_i held high.
REQ-021 Simultaneous output fire and transfer: new word replaces old, valid_o stays 1, no bubble.
REQ-022 Symbols are never dropped or duplicated; valid_i without ready_o changes no state.

Reset
REQ-023 While reset_ni = 0: valid_o = 0, packed_o = 0, count_o = 0, slot counter = 0, accumulator = 0, immediately and independent of clk_i.
REQ-024 ready_o = 1 in the first cycle after reset_ni deasserts.
REQ-025 Reset mid-word discards all partially accumulated symbols and any held output word.

Configuration
REQ-026 Macro PACKER_FLUSH_EN enables partial-word flush.
REQ-027 With PACKER_FLUSH_EN defined: input fire with flush_i = 1 at slot k transfers the word immediately; slots above k read 0; count_o = k+1; the counter resets to 0.
REQ-028 With PACKER_FLUSH_EN defined: ready_o = !valid_o || ready_i, independent of slot.
REQ-029 Without PACKER_FLUSH_EN: flush_i is ignored, count_o always equals num_packed_p when valid_o = 1, and REQ-019 governs ready_o.

Verification
REQ-030 Defaults, ready_i = 1, symbols 1,2,3,0 on consecutive cycles -> one cycle after the 4th, valid_o = 1, packed_o = 0x39, count_o = 4.
REQ-031 ready_i = 0, 8 symbols offered back-to-back (all 3) -> packed_o = 0xFF held, ready_o = 0 at slot 3 with valid_o = 1; raise ready_i -> two words 0xFF, no loss.
REQ-032 ready_i = 1, 16 symbols cycling 0,1,2,3 continuously -> four words 0xE4, one every 4 cycles, ready_o never low.
REQ-033 Accept 2 symbols, pulse reset_ni low mid-cycle, then symbols 0,0,0,1 -> only word 0x40 emitted; valid_o = 0 during reset.
REQ-034 PACKER_FLUSH_EN: symbols 3, then 1 with flush_i = 1 -> packed_o = 0x07, count_o = 2; next four symbols 2,2,2,2 -> 0xAA, count_o = 4.
REQ-035 Without PACKER_FLUSH_EN: same stimulus as REQ-034 -> flush_i has no effect; first word completes after 4 symbols with count_o = 4.
